user_rom_streamer: RTL

USER_ROM_STREAMER -- requirements
Module: user_rom_streamer

---
 rtl/user_rom_streamer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/user_rom_streamer.sv
// Streams a zero-terminated byte string out of a word-organised ROM over an
// OBI manager port: one read per word, bytes emitted little-endian on a valid/ready link.

package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32'd32, DataWidth: 32'd32, IdWidth: 32'd1};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
    logic [0:0]  a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

module user_rom_streamer #(
  parameter obi_pkg::obi_cfg_t ObiCfg   = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t = obi_pkg::obi_req_t,
  parameter type               obi_rsp_t = obi_pkg::obi_rsp_t,
  parameter logic [31:0]       BaseAddr  = 32'h0000_0000,
  parameter int unsigned       MaxWords  = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output obi_req_t    obi_req_o,
  input  obi_rsp_t    obi_rsp_i,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  input  logic        byte_ready_i,
  output logic [15:0] count_o
);

  localparam int unsigned    IdxW      = (MaxWords > 1) ? $clog2(MaxWords) : 1;
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(MaxWords - 1);
  localparam logic [31:0]    WordBytes = 32'(ObiCfg.DataWidth / 32'd8);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e          state_r;
  logic [IdxW-1:0] index_r;
  logic [1:0]      ptr_r;
  logic [31:0]     word_r;
  logic [31:0]     addr_r;
  logic [15:0]     count_r;
  logic            err_r;
  logic            done_r;
  logic            busy_r;
  logic            req_r;
  logic [7:0]      byte_r;
  logic            byte_valid_r;

  logic [1:0]      nxt_ptr_s;
  logic [7:0]      nxt_byte_s;
  logic [IdxW-1:0] nxt_idx_s;
  logic            last_word_s;
  logic [15:0]     count_inc_s;

  function automatic logic [31:0] word_addr(input logic [IdxW-1:0] idx);
    return BaseAddr + (32'(idx) * WordBytes);
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Look-ahead values for the byte after the one currently presented.
  always_comb begin
    nxt_ptr_s   = ptr_r + 2'd1;
    nxt_byte_s  = pick_byte(word_r, nxt_ptr_s);
    nxt_idx_s   = index_r + IdxW'(1);
    last_word_s = (index_r == LastIdx);
    if (count_r == 16'hFFFF) begin
      count_inc_s = count_r;
    end else begin
      count_inc_s = count_r + 16'd1;
    end
  end

  // Run sequencer; every output is a register updated on the transition into its state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= ST_IDLE;
      index_r      <= '0;
      ptr_r        <= 2'd0;
      word_r       <= 32'h0000_0000;
      addr_r       <= 32'h0000_0000;
      count_r      <= 16'h0000;
      err_r        <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
      req_r        <= 1'b0;
      byte_r       <= 8'h00;
      byte_valid_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            state_r <= ST_REQ;
            busy_r  <= 1'b1;
            index_r <= '0;
            err_r   <= 1'b0;
            count_r <= 16'h0000;
            addr_r  <= BaseAddr;
            req_r   <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (obi_rsp_i.gnt) begin
            state_r <= ST_WAIT;
            req_r   <= 1'b0;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (obi_rsp_i.rvalid && obi_rsp_i.r.err) begin
            err_r   <= 1'b1;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else if (obi_rsp_i.rvalid) begin
            word_r       <= obi_rsp_i.r.rdata;
            ptr_r        <= 2'd0;
            byte_r       <= pick_byte(obi_rsp_i.r.rdata, 2'd0);
            byte_valid_r <= (pick_byte(obi_rsp_i.r.rdata, 2'd0) != 8'h00);
            state_r      <= ST_DRAIN;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_DRAIN: begin
          // A presented zero byte is the terminator: it is never offered downstream.
          if (!byte_valid_r) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else if (byte_ready_i) begin
            count_r <= count_inc_s;
            ptr_r   <= nxt_ptr_s;
            if (ptr_r == 2'd3) begin
              byte_valid_r <= 1'b0;
              if (last_word_s) begin
                done_r  <= 1'b1;
                state_r <= ST_DONE;
              end else begin
                index_r <= nxt_idx_s;
                addr_r  <= word_addr(nxt_idx_s);
                req_r   <= 1'b1;
                state_r <= ST_REQ;
              end
            end else begin
              byte_r       <= nxt_byte_s;
              byte_valid_r <= (nxt_byte_s != 8'h00);
            end
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r      <= ST_IDLE;
          busy_r       <= 1'b0;
          req_r        <= 1'b0;
          byte_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Read-only single-word requests: only address and req vary.
  always_comb begin
    obi_req_o        = '0;
    obi_req_o.req    = req_r;
    obi_req_o.a.addr = addr_r;
    obi_req_o.a.be   = 4'hF;
  end

  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign err_o        = err_r;
  assign byte_o       = byte_r;
  assign byte_valid_o = byte_valid_r;
  assign count_o      = count_r;

endmodule
